// File: rtl/sdr_16_arbiter_pkg.sv
// Shared constants, arbitration state encoding and index helpers for the SDR arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdr_16_arbiter_pkg;

    localparam int nr_fifo   = 16;
    localparam int nr_domain = 4;
    localparam int idx_w     = $clog2(nr_fifo);
    localparam int dom_w     = $clog2(nr_domain);

    // ARB: looking for a requester; OFFER: select presented to the controller;
    // BUSY: controller owns a transaction, select held at zero.
    typedef enum logic [1:0] {
        ARB   = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

    // Each clock domain owns four consecutive FIFOs.
    function automatic logic [dom_w-1:0] fifo_domain(input logic [idx_w-1:0] idx);
        return idx[idx_w-1:idx_w-dom_w];
    endfunction

endpackage

// File: rtl/sdr_16_arbiter_rr_pick16.sv
// Round-robin picker: first set request at or after the pointer, wrapping 15->0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module sdr_16_arbiter_rr_pick16
    import sdr_16_arbiter_pkg::*;
(
    input  logic [0:nr_fifo-1] req,
    input  logic [idx_w-1:0]   ptr,
    output logic [0:nr_fifo-1] gnt,
    output logic [idx_w-1:0]   idx,
    output logic               vld
);

    logic [idx_w-1:0] cand;

    // Scan the 16 positions starting at the pointer; the first hit wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        vld  = 1'b0;
        cand = '0;
        for (int i = 0; i < nr_fifo; i++) begin
            cand = ptr + idx_w'(i);
            if (!vld && req[cand]) begin
                vld = 1'b1;
                idx = cand;
            end
        end
        gnt[idx] = vld;
    end

endmodule

// File: rtl/sdr_16_arbiter.sv
// Round-robin FIFO select and periodic auto-refresh request for the 16-bit SDR control FSM.
// Latency: request -> select 1 cycle; taken -> select cleared 1 cycle; done -> next offer >= 2 cycles.
// Backpressure: an offer is held until sel_taken_i or withdrawal; refresh holds one pending request.
module sdr_16_arbiter
    import sdr_16_arbiter_pkg::*;
#(
    parameter int refresh_interval = 390,
    parameter int cnt_w            = 10
) (
    input  logic               sdram_clk,
    input  logic               sdram_rst,
    input  logic [0:nr_fifo-1] req_i,
    input  logic               sel_taken_i,
    input  logic               done_i,
    input  logic               cmd_aref_i,
    output logic [0:nr_fifo-1] fifo_sel_o,
    output logic [dom_w-1:0]   fifo_sel_domain_o,
    output logic               refresh_req_o,
    output logic               busy_o,
    output logic               refresh_overrun_o
);

    localparam logic [cnt_w-1:0] reload_val = cnt_w'(refresh_interval - 1);

    arb_state_t         state_q, state_nxt;
    logic [idx_w-1:0]   ptr_q, ptr_nxt;
    logic [idx_w-1:0]   gidx_q, gidx_nxt;
    logic [0:nr_fifo-1] sel_q, sel_nxt;
    logic [dom_w-1:0]   dom_q, dom_nxt;
    logic               busy_q;

    logic [0:nr_fifo-1] pick_gnt;
    logic [idx_w-1:0]   pick_idx;
    logic               pick_vld;

    logic [cnt_w-1:0]   refresh_cnt_q;
    logic               refresh_req_q;
    logic               refresh_overrun_q;
    logic               refresh_expire;

    sdr_16_arbiter_rr_pick16 u_pick (
        .req (req_i),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    // Arbitration state and registered select outputs; reset drops any offer or grant.
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            state_q <= ARB;
            ptr_q   <= '0;
            gidx_q  <= '0;
            sel_q   <= '0;
            dom_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            ptr_q   <= ptr_nxt;
            gidx_q  <= gidx_nxt;
            sel_q   <= sel_nxt;
            dom_q   <= dom_nxt;
            busy_q  <= (state_nxt == BUSY);
        end
    end

    // Next-state logic; the select is zero outside OFFER so the controller never sees a stale grant.
    always_comb begin
        state_nxt = state_q;
        ptr_nxt   = ptr_q;
        gidx_nxt  = gidx_q;
        sel_nxt   = sel_q;
        dom_nxt   = dom_q;
        case (state_q)
            ARB: begin
                sel_nxt = '0;
                dom_nxt = '0;
                if (pick_vld) begin
                    state_nxt = OFFER;
                    sel_nxt   = pick_gnt;
                    dom_nxt   = fifo_domain(pick_idx);
                    gidx_nxt  = pick_idx;
                end
            end
            OFFER: begin
                // Taken beats a same-cycle withdrawal; the pointer only advances on a real grant.
                if (sel_taken_i) begin
                    state_nxt = BUSY;
                    ptr_nxt   = gidx_q + idx_w'(1);
                    sel_nxt   = '0;
                    dom_nxt   = '0;
                end else if (!req_i[gidx_q]) begin
                    state_nxt = ARB;
                    sel_nxt   = '0;
                    dom_nxt   = '0;
                end
            end
            BUSY: begin
                sel_nxt = '0;
                dom_nxt = '0;
                if (done_i) begin
                    state_nxt = ARB;
                end
            end
            default: begin
                state_nxt = ARB;
                sel_nxt   = '0;
                dom_nxt   = '0;
            end
        endcase
    end

    assign refresh_expire = (refresh_cnt_q == '0);

    // Free-running refresh timer: one pending request, a fresh expiry beats a same-cycle ack,
    // and an expiry on an unacknowledged request is flagged until reset.
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            refresh_cnt_q     <= reload_val;
            refresh_req_q     <= 1'b0;
            refresh_overrun_q <= 1'b0;
        end else begin
            if (refresh_expire) begin
                refresh_cnt_q <= reload_val;
                refresh_req_q <= 1'b1;
                if (refresh_req_q && !cmd_aref_i) begin
                    refresh_overrun_q <= 1'b1;
                end
            end else begin
                refresh_cnt_q <= refresh_cnt_q - cnt_w'(1);
                if (cmd_aref_i) begin
                    refresh_req_q <= 1'b0;
                end
            end
        end
    end

    assign fifo_sel_o        = sel_q;
    assign fifo_sel_domain_o = dom_q;
    assign busy_o            = busy_q;
    assign refresh_req_o     = refresh_req_q;
    assign refresh_overrun_o = refresh_overrun_q;

endmodule

// File: tb/tb_sdr_16_arbiter.sv
// Directed bench for sdr_16_arbiter with a short refresh interval of 8 cycles.
// Latency: cycle counter cyc counts rising edges since the last reset edge.
// Backpressure: controller strobes are driven directly by the bench tasks.
module tb_sdr_16_arbiter;

    logic        sdram_clk = 1'b0;
    logic        sdram_rst = 1'b1;
    logic [0:15] req_i = '0;
    logic        sel_taken_i = 1'b0;
    logic        done_i = 1'b0;
    logic        cmd_aref_i = 1'b0;
    logic [0:15] fifo_sel_o;
    logic [1:0]  fifo_sel_domain_o;
    logic        refresh_req_o;
    logic        busy_o;
    logic        refresh_overrun_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    sdr_16_arbiter #(
        .refresh_interval (8),
        .cnt_w            (4)
    ) dut (
        .sdram_clk         (sdram_clk),
        .sdram_rst         (sdram_rst),
        .req_i             (req_i),
        .sel_taken_i       (sel_taken_i),
        .done_i            (done_i),
        .cmd_aref_i        (cmd_aref_i),
        .fifo_sel_o        (fifo_sel_o),
        .fifo_sel_domain_o (fifo_sel_domain_o),
        .refresh_req_o     (refresh_req_o),
        .busy_o            (busy_o),
        .refresh_overrun_o (refresh_overrun_o)
    );

    always #5 sdram_clk = ~sdram_clk;

    function automatic logic [0:15] oh(input int n);
        logic [0:15] v;
        v    = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    function automatic int first_idx(input logic [0:15] s);
        for (int i = 0; i < 16; i++) begin
            if (s[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge sdram_clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        sdram_rst   = 1'b1;
        req_i       = '0;
        sel_taken_i = 1'b0;
        done_i      = 1'b0;
        cmd_aref_i  = 1'b0;
        tick();
        sdram_rst = 1'b0;
        cyc       = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (fifo_sel_o !== 16'h0000) begin n_fail++; $display("FAIL reset_sel: got %h expected 0000", fifo_sel_o); end
        n_checks++;
        if (fifo_sel_domain_o !== 2'd0) begin n_fail++; $display("FAIL reset_dom: got %0d expected 0", fifo_sel_domain_o); end
        n_checks++;
        if ({busy_o, refresh_req_o, refresh_overrun_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got busy/ref/ovr %b expected 000", {busy_o, refresh_req_o, refresh_overrun_o});
        end
    endtask

    task automatic test_refresh();
        do_reset();
        run_to(7);
        n_checks++;
        if (refresh_req_o !== 1'b0) begin n_fail++; $display("FAIL ref_early: got %b expected 0 at cycle 7", refresh_req_o); end
        run_to(8);
        n_checks++;
        if (refresh_req_o !== 1'b1) begin n_fail++; $display("FAIL ref_first: got %b expected 1 at cycle 8", refresh_req_o); end
        run_to(10);
        cmd_aref_i = 1'b1;
        run_to(11);
        cmd_aref_i = 1'b0;
        n_checks++;
        if (refresh_req_o !== 1'b0) begin n_fail++; $display("FAIL ref_ack: got %b expected 0 at cycle 11", refresh_req_o); end
        run_to(15);
        n_checks++;
        if (refresh_req_o !== 1'b0) begin n_fail++; $display("FAIL ref_gap: got %b expected 0 at cycle 15", refresh_req_o); end
        run_to(16);
        n_checks++;
        if (refresh_req_o !== 1'b1) begin n_fail++; $display("FAIL ref_second: got %b expected 1 at cycle 16", refresh_req_o); end
        run_to(23);
        n_checks++;
        if (refresh_overrun_o !== 1'b0) begin n_fail++; $display("FAIL ovr_early: got %b expected 0 at cycle 23", refresh_overrun_o); end
        run_to(25);
        n_checks++;
        if ({refresh_overrun_o, refresh_req_o} !== 2'b11) begin
            n_fail++; $display("FAIL ovr_set: got ovr/req %b expected 11 at cycle 25", {refresh_overrun_o, refresh_req_o});
        end
        run_to(31);
        cmd_aref_i = 1'b1;
        run_to(32);
        cmd_aref_i = 1'b0;
        n_checks++;
        if (refresh_req_o !== 1'b1) begin n_fail++; $display("FAIL ref_ack_expiry: got %b expected 1 at cycle 32", refresh_req_o); end
        cmd_aref_i = 1'b1;
        run_to(33);
        cmd_aref_i = 1'b0;
        n_checks++;
        if (refresh_req_o !== 1'b0) begin n_fail++; $display("FAIL ref_ack_late: got %b expected 0 at cycle 33", refresh_req_o); end
    endtask

    task automatic test_basic();
        do_reset();
        run_to(2);
        n_checks++;
        if (fifo_sel_o !== 16'h0000) begin n_fail++; $display("FAIL basic_idle: got %h expected 0000", fifo_sel_o); end
        req_i = oh(5);
        run_to(3);
        n_checks++;
        if (fifo_sel_o !== oh(5) || fifo_sel_domain_o !== 2'd1) begin
            n_fail++; $display("FAIL basic_offer: got sel %h dom %0d expected %h dom 1", fifo_sel_o, fifo_sel_domain_o, oh(5));
        end
        run_to(4);
        sel_taken_i = 1'b1;
        run_to(5);
        sel_taken_i = 1'b0;
        req_i       = '0;
        n_checks++;
        if (fifo_sel_o !== 16'h0000 || fifo_sel_domain_o !== 2'd0 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL basic_taken: got sel %h dom %0d busy %b expected 0000 0 1", fifo_sel_o, fifo_sel_domain_o, busy_o);
        end
        run_to(8);
        n_checks++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL basic_busy_hold: got %b expected 1", busy_o); end
        done_i = 1'b1;
        run_to(9);
        done_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || fifo_sel_o !== 16'h0000) begin
            n_fail++; $display("FAIL basic_done: got busy %b sel %h expected 0 0000", busy_o, fifo_sel_o);
        end
        run_to(10);
        n_checks++;
        if (fifo_sel_o !== 16'h0000) begin n_fail++; $display("FAIL basic_no_req: got %h expected 0000", fifo_sel_o); end
    endtask

    task automatic test_round_robin();
        int seen[16];
        int got;
        for (int i = 0; i < 16; i++) seen[i] = 0;
        do_reset();
        req_i = '1;
        run_to(1);
        for (int k = 0; k < 17; k++) begin
            got = first_idx(fifo_sel_o);
            n_checks++;
            if (got != (k % 16) || $countones(fifo_sel_o) != 1 || fifo_sel_domain_o !== 2'((k % 16) / 4)) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got sel %h dom %0d expected index %0d dom %0d", k, fifo_sel_o, fifo_sel_domain_o, k % 16, (k % 16) / 4);
            end
            if (k < 16 && got >= 0) seen[got]++;
            sel_taken_i = 1'b1;
            tick();
            sel_taken_i = 1'b0;
            n_checks++;
            if (busy_o !== 1'b1 || fifo_sel_o !== 16'h0000) begin
                n_fail++; $display("FAIL rr_busy%0d: got busy %b sel %h expected 1 0000", k, busy_o, fifo_sel_o);
            end
            done_i = 1'b1;
            tick();
            done_i = 1'b0;
            n_checks++;
            if (fifo_sel_o !== 16'h0000 || busy_o !== 1'b0) begin
                n_fail++; $display("FAIL rr_gap%0d: got sel %h busy %b expected 0000 0", k, fifo_sel_o, busy_o);
            end
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (seen[i] != 1) begin n_fail++; $display("FAIL rr_once%0d: got %0d grants expected 1", i, seen[i]); end
        end
        req_i = '0;
    endtask

    task automatic test_wrap();
        do_reset();
        req_i = oh(13);
        run_to(1);
        n_checks++;
        if (fifo_sel_o !== oh(13)) begin n_fail++; $display("FAIL wrap_setup: got %h expected %h", fifo_sel_o, oh(13)); end
        sel_taken_i = 1'b1;
        run_to(2);
        sel_taken_i = 1'b0;
        done_i      = 1'b1;
        run_to(3);
        done_i = 1'b0;
        req_i  = oh(3) | oh(15);
        run_to(4);
        n_checks++;
        if (fifo_sel_o !== oh(15) || fifo_sel_domain_o !== 2'd3) begin
            n_fail++; $display("FAIL wrap_15: got sel %h dom %0d expected %h dom 3", fifo_sel_o, fifo_sel_domain_o, oh(15));
        end
        sel_taken_i = 1'b1;
        run_to(5);
        sel_taken_i = 1'b0;
        done_i      = 1'b1;
        run_to(6);
        done_i = 1'b0;
        run_to(7);
        n_checks++;
        if (fifo_sel_o !== oh(3) || fifo_sel_domain_o !== 2'd0) begin
            n_fail++; $display("FAIL wrap_3: got sel %h dom %0d expected %h dom 0", fifo_sel_o, fifo_sel_domain_o, oh(3));
        end
        req_i = '0;
    endtask

    task automatic test_withdraw();
        do_reset();
        req_i = oh(7);
        run_to(1);
        n_checks++;
        if (fifo_sel_o !== oh(7) || fifo_sel_domain_o !== 2'd1) begin
            n_fail++; $display("FAIL wd_offer: got sel %h dom %0d expected %h dom 1", fifo_sel_o, fifo_sel_domain_o, oh(7));
        end
        req_i = oh(7) | oh(2);
        run_to(2);
        n_checks++;
        if (fifo_sel_o !== oh(7)) begin n_fail++; $display("FAIL wd_stable: got %h expected %h", fifo_sel_o, oh(7)); end
        req_i = oh(2);
        run_to(3);
        n_checks++;
        if (fifo_sel_o !== 16'h0000 || fifo_sel_domain_o !== 2'd0 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL wd_clear: got sel %h dom %0d busy %b expected 0000 0 0", fifo_sel_o, fifo_sel_domain_o, busy_o);
        end
        run_to(4);
        n_checks++;
        if (fifo_sel_o !== oh(2)) begin n_fail++; $display("FAIL wd_reoffer: got %h expected %h", fifo_sel_o, oh(2)); end
        req_i       = '0;
        sel_taken_i = 1'b1;
        run_to(5);
        sel_taken_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b1 || fifo_sel_o !== 16'h0000) begin
            n_fail++; $display("FAIL wd_taken_wins: got busy %b sel %h expected 1 0000", busy_o, fifo_sel_o);
        end
        done_i = 1'b1;
        run_to(6);
        done_i = 1'b0;
        run_to(7);
        n_checks++;
        if (fifo_sel_o !== 16'h0000 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL wd_idle: got sel %h busy %b expected 0000 0", fifo_sel_o, busy_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_i = oh(5);
        run_to(1);
        sel_taken_i = 1'b1;
        run_to(2);
        sel_taken_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rst_busy_setup: got %b expected 1", busy_o); end
        req_i     = oh(3) | oh(9);
        sdram_rst = 1'b1;
        run_to(3);
        sdram_rst = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || fifo_sel_o !== 16'h0000 || fifo_sel_domain_o !== 2'd0 || refresh_req_o !== 1'b0 || refresh_overrun_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_busy: got busy %b sel %h dom %0d ref %b ovr %b expected all 0", busy_o, fifo_sel_o, fifo_sel_domain_o, refresh_req_o, refresh_overrun_o);
        end
        run_to(4);
        n_checks++;
        if (fifo_sel_o !== oh(3)) begin n_fail++; $display("FAIL rst_ptr0: got %h expected %h", fifo_sel_o, oh(3)); end
        req_i     = oh(9);
        sdram_rst = 1'b1;
        tick();
        sdram_rst = 1'b0;
        cyc       = 0;
        n_checks++;
        if (busy_o !== 1'b0 || fifo_sel_o !== 16'h0000 || fifo_sel_domain_o !== 2'd0) begin
            n_fail++; $display("FAIL rst_offer: got busy %b sel %h dom %0d expected 0 0000 0", busy_o, fifo_sel_o, fifo_sel_domain_o);
        end
        run_to(1);
        n_checks++;
        if (fifo_sel_o !== oh(9) || fifo_sel_domain_o !== 2'd2) begin
            n_fail++; $display("FAIL rst_reoffer: got sel %h dom %0d expected %h dom 2", fifo_sel_o, fifo_sel_domain_o, oh(9));
        end
        run_to(7);
        n_checks++;
        if (refresh_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_cnt_early: got %b expected 0", refresh_req_o); end
        run_to(8);
        n_checks++;
        if (refresh_req_o !== 1'b1) begin n_fail++; $display("FAIL rst_cnt_reload: got %b expected 1", refresh_req_o); end
        req_i = '0;
    endtask

    initial begin
        test_reset();
        test_refresh();
        test_basic();
        test_round_robin();
        test_wrap();
        test_withdraw();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
